fifo_uart_streamer: RTL

//  Drains 64-bit words from the output FIFO (filled from PSRAM by the storage controller) and

---
 rtl/fifo_uart_streamer_pkg.sv | 28 ++
 rtl/fifo_uart_streamer_uart_tx_byte.sv | 80 ++++++++
 rtl/fifo_uart_streamer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_streamer_pkg.sv
// ----------------------------------------------------------------------------
// fifo_uart_streamer_pkg
// Shared definitions for the FIFO-to-UART word streamer:
//   - default clock / baud figures used to derive cycles per UART bit
//   - default sync marker byte (used only when UART_WORD_SYNC_EN is defined)
//   - top-level FSM state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package fifo_uart_streamer_pkg;

    localparam int         DEF_CLK_FREQ   = 160_000_000;
    localparam int         DEF_BAUD_RATE  = 2_000_000;
    localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;

    localparam int         BYTES_PER_WORD = 8;
    localparam int         BITS_PER_FRAME = 10;   // start + 8 data + stop

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LATCH,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

endpackage

// File: rtl/fifo_uart_streamer_uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte
// Frames one byte as UART 8N1 (start, 8 data bits LSB first, stop) and owns
// the bit timer. A new byte may be loaded while idle or in the last cycle of
// the stop bit (done=1), which gives gap-free back-to-back frames.
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   synchronous reset, active low (line returns high)
//   load       in   accept load_data and start a frame next cycle
//   load_data  in   byte to send
//   tx         out  serial line, idle high, registered
//   busy       out  frame in progress
//   start_end  out  last cycle of the start bit
//   data_end   out  last cycle of data bit 7
//   done       out  last cycle of the stop bit
// ----------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 80        // minimum 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       tx,
    output logic       busy,
    output logic       start_end,
    output logic       data_end,
    output logic       done
);

    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    logic [TMR_W-1:0] bit_tmr;
    logic [3:0]       bit_pos;    // 0 start, 1..8 data, 9 stop
    logic [7:0]       data_sr;
    logic             active;
    logic             bit_end;

    assign bit_end   = active && (bit_tmr == TMR_LAST);
    assign start_end = bit_end && (bit_pos == 4'd0);
    assign data_end  = bit_end && (bit_pos == 4'd8);
    assign done      = bit_end && (bit_pos == 4'd9);
    assign busy      = active;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            active  <= 1'b0;
            tx      <= 1'b1;
            bit_tmr <= '0;
            bit_pos <= '0;
            data_sr <= '1;
        end else if (load) begin
            active  <= 1'b1;
            tx      <= 1'b0;
            bit_tmr <= '0;
            bit_pos <= '0;
            data_sr <= load_data;
        end else if (active) begin
            if (bit_end) begin
                bit_tmr <= '0;
                if (bit_pos == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_pos <= bit_pos + 4'd1;
                    if (bit_pos <= 4'd7) begin
                        // ones shift in behind the data so the line rests high
                        tx      <= data_sr[0];
                        data_sr <= {1'b1, data_sr[7:1]};
                    end else begin
                        tx <= 1'b1;
                    end
                end
            end else begin
                bit_tmr <= bit_tmr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_uart_streamer.sv
// ----------------------------------------------------------------------------
// fifo_uart_streamer
// Drains 64-bit words from the output FIFO and sends each one as 8 UART 8N1
// bytes, LSB byte first. A word is read only when the previous one has fully
// left the line, so the FIFO is never over-read.
// Optional build macro: UART_WORD_SYNC_EN -- prefixes every word with the
// SYNC_BYTE marker framed as an ordinary 8N1 byte.
// Ports:
//   sys_clk         in   system clock
//   sys_rst_n       in   synchronous reset, active low
//   stream_en       in   allow a new word to start
//   fifo_empty      in   output FIFO empty flag
//   fifo_read_en    out  one-cycle read strobe per word
//   fifo_read_data  in   64-bit FIFO data, valid the cycle after the strobe
//   uart_tx         out  serial line, idle high
//   busy            out  high from the FIFO read until the last stop bit ends
//   word_count      out  words fully transmitted, wraps at 2^32
//
// state    | meaning
// IDLE     | waiting for stream_en && !fifo_empty; issues the read strobe
// WAIT     | FIFO read latency
// LATCH    | capture the word, load the first frame
// SYNC     | marker byte on the line (UART_WORD_SYNC_EN only)
// START    | start bit of a data byte
// DATA     | data bits of a data byte
// STOP     | stop bit; chains the next byte or finishes the word
// ----------------------------------------------------------------------------
module fifo_uart_streamer
    import fifo_uart_streamer_pkg::*;
#(
    parameter int         CLK_FREQ     = DEF_CLK_FREQ,
    parameter int         BAUD_RATE    = DEF_BAUD_RATE,
`ifdef UART_WORD_SYNC_EN
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
`endif
    parameter int         CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        stream_en,
    input  logic        fifo_empty,
    output logic        fifo_read_en,
    input  logic [63:0] fifo_read_data,
    output logic        uart_tx,
    output logic        busy,
    output logic [31:0] word_count
);

    state_t      state;
    state_t      state_n;
    logic [63:0] shift_word;
    logic [2:0]  byte_idx;

    logic        rd_req;
    logic        latch_en;
    logic        shift_en;
    logic        word_done;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_start_end;
    logic        tx_data_end;
    logic        tx_done;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (tx_load),
        .load_data (tx_data),
        .tx        (uart_tx),
        .busy      (tx_busy),
        .start_end (tx_start_end),
        .data_end  (tx_data_end),
        .done      (tx_done)
    );

    // The strobe is a Mealy output of IDLE; masking it with reset keeps a
    // reset cycle from popping a FIFO word that would then be thrown away.
    assign fifo_read_en = rd_req && sys_rst_n;
    assign busy         = (state != ST_IDLE) || fifo_read_en;

    always_comb begin
        state_n   = state;
        rd_req    = 1'b0;
        latch_en  = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        tx_load   = 1'b0;
        tx_data   = shift_word[7:0];

        case (state)
            ST_IDLE: begin
                if (stream_en && !fifo_empty && !tx_busy) begin
                    rd_req  = 1'b1;
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_n = ST_LATCH;
            end
            ST_LATCH: begin
                latch_en = 1'b1;
                tx_load  = 1'b1;
`ifdef UART_WORD_SYNC_EN
                tx_data  = SYNC_BYTE;
                state_n  = ST_SYNC;
`else
                // shift_word is written at this edge, so byte 0 comes straight off the bus
                tx_data  = fifo_read_data[7:0];
                state_n  = ST_START;
`endif
            end
`ifdef UART_WORD_SYNC_EN
            ST_SYNC: begin
                if (tx_done) begin
                    tx_load = 1'b1;
                    tx_data = shift_word[7:0];
                    state_n = ST_START;
                end
            end
`endif
            ST_START: begin
                if (tx_start_end) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_data_end) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_done) begin
                    if (byte_idx != 3'd7) begin
                        // next byte is loaded in the stop bit's last cycle: no idle gap
                        tx_load  = 1'b1;
                        tx_data  = shift_word[15:8];
                        shift_en = 1'b1;
                        state_n  = ST_START;
                    end else begin
                        word_done = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            shift_word <= '0;
            byte_idx   <= '0;
            word_count <= '0;
        end else begin
            state <= state_n;
            if (latch_en) begin
                shift_word <= fifo_read_data;
                byte_idx   <= '0;
            end else if (shift_en) begin
                shift_word <= {8'h00, shift_word[63:8]};
                byte_idx   <= byte_idx + 3'd1;
            end
            if (word_done) begin
                word_count <= word_count + 32'd1;
            end
        end
    end

endmodule
